// File: rtl/sram_counter_host.sv
// Host-side initiator for the SRAM multi-counter: issues counter commands,
// tracks the 1-cycle READ responses into a credit-protected FIFO and runs a 256-entry dump.
module sram_counter_host #(
    parameter int RSP_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_cmd,
    input  logic [7:0] req_id,
    input  logic [7:0] req_data,
    input  logic       dump_start,
    output logic       dump_busy,
    output logic       ctr_valid,
    output logic [2:0] ctr_cmd,
    output logic [7:0] ctr_id,
    output logic [7:0] ctr_data,
    input  logic       ctr_rsp_valid,
    input  logic [7:0] ctr_rsp_id,
    input  logic [7:0] ctr_rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_dump,
    output logic [2:0] err
);

    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] CMD_LOAD = 3'd0;
    localparam logic [2:0] CMD_READ = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_idx;
    logic [7:0]      w_idx_nxt;
    logic            r_run;

    logic            r_ctr_valid;
    logic [2:0]      r_ctr_cmd;
    logic [7:0]      r_ctr_id;
    logic [7:0]      r_ctr_data;
    logic            r_ctr_dump;

    logic            r_exp;
    logic [7:0]      r_exp_id;
    logic            r_exp_dump;
    logic [2:0]      r_err;

    logic [16:0]     r_mem [RSP_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_ctr_rd;
    logic [CW+1:0]   w_credit_sum;
    logic            w_credit;
    logic            w_req_ready;
    logic            w_accept;
    logic            w_dump_issue;

    logic            w_iss_valid;
    logic [2:0]      w_iss_cmd;
    logic [7:0]      w_iss_id;
    logic [7:0]      w_iss_data;
    logic            w_iss_dump;

    logic            w_push;
    logic [16:0]     w_push_word;
    logic [2:0]      w_err_set;
    logic            w_pop;
    logic            w_full;
    logic            w_push_ok;
    logic            w_fifo_nonempty;

    // Credit counts stored entries plus reads on the wire and reads awaiting response.
    always_comb begin
        w_ctr_rd     = r_ctr_valid & (r_ctr_cmd == CMD_READ);
        w_credit_sum = (CW+2)'(r_count) + (CW+2)'(w_ctr_rd) + (CW+2)'(r_exp);
        w_credit     = w_credit_sum < (CW+2)'(RSP_DEPTH);
        w_req_ready  = r_run & (r_state == ST_IDLE) & w_credit;
        w_accept     = req_valid & w_req_ready;
        w_dump_issue = (r_state == ST_DUMP) & w_credit;
    end

    // FSM next-state and dump index.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (dump_start) begin
                    w_state_nxt = ST_DUMP;
                    w_idx_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DUMP: begin
                if (w_dump_issue) begin
                    if (r_idx == 8'd255) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = 8'd0;
                    end else begin
                        w_idx_nxt   = r_idx + 8'd1;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 8'd0;
            end
        endcase
    end

    // Select the command for the next cycle; opcodes 5-7 are swallowed silently.
    always_comb begin
        w_iss_valid = 1'b0;
        w_iss_cmd   = 3'd0;
        w_iss_id    = 8'd0;
        w_iss_data  = 8'd0;
        w_iss_dump  = 1'b0;
        if (w_accept) begin
            if (req_cmd <= CMD_READ) begin
                w_iss_valid = 1'b1;
                w_iss_cmd   = req_cmd;
                w_iss_id    = req_id;
                w_iss_data  = (req_cmd == CMD_LOAD) ? req_data : 8'd0;
            end else begin
                w_iss_valid = 1'b0;
            end
        end else if (w_dump_issue) begin
            w_iss_valid = 1'b1;
            w_iss_cmd   = CMD_READ;
            w_iss_id    = r_idx;
            w_iss_dump  = 1'b1;
        end else begin
            w_iss_valid = 1'b0;
        end
    end

    // Match counter responses against the expected-read slot.
    always_comb begin
        w_push      = 1'b0;
        w_push_word = {r_exp_id, ctr_rsp_data, r_exp_dump};
        w_err_set   = 3'b000;
        if (ctr_rsp_valid & r_exp) begin
            w_push = 1'b1;
            if (ctr_rsp_id != r_exp_id) begin
                w_err_set[2] = 1'b1;
            end else begin
                w_err_set[2] = 1'b0;
            end
        end else if (ctr_rsp_valid) begin
            w_err_set[0] = 1'b1;
        end else if (r_exp) begin
            w_err_set[1] = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // FIFO handshake; an overflowing push is dropped and flagged as unexpected.
    always_comb begin
        w_fifo_nonempty = (r_count != CW'(0));
        w_pop           = w_fifo_nonempty & rsp_ready;
        w_full          = (r_count == CW'(RSP_DEPTH));
        w_push_ok       = w_push & (~w_full | w_pop);
    end

    // State, dump index and out-of-reset flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 8'd0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_run   <= 1'b1;
        end
    end

    // Registered counter command port and response expectation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr_valid <= 1'b0;
            r_ctr_cmd   <= 3'd0;
            r_ctr_id    <= 8'd0;
            r_ctr_data  <= 8'd0;
            r_ctr_dump  <= 1'b0;
            r_exp       <= 1'b0;
            r_exp_id    <= 8'd0;
            r_exp_dump  <= 1'b0;
        end else begin
            r_ctr_valid <= w_iss_valid;
            r_ctr_cmd   <= w_iss_cmd;
            r_ctr_id    <= w_iss_id;
            r_ctr_data  <= w_iss_data;
            r_ctr_dump  <= w_iss_dump;
            r_exp       <= w_ctr_rd;
            r_exp_id    <= r_ctr_id;
            r_exp_dump  <= r_ctr_dump;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 3'b000;
        end else begin
            r_err <= r_err | w_err_set | {2'b00, w_push & ~w_push_ok};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: {id, data, dump}.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    assign req_ready = w_req_ready;
    assign dump_busy = (r_state == ST_DUMP);
    assign ctr_valid = r_ctr_valid;
    assign ctr_cmd   = r_ctr_cmd;
    assign ctr_id    = r_ctr_id;
    assign ctr_data  = r_ctr_data;
    assign rsp_valid = w_fifo_nonempty;
    assign rsp_id    = w_fifo_nonempty ? r_mem[r_rd_ptr][16:9] : 8'd0;
    assign rsp_data  = w_fifo_nonempty ? r_mem[r_rd_ptr][8:1]  : 8'd0;
    assign rsp_dump  = w_fifo_nonempty ? r_mem[r_rd_ptr][0]    : 1'b0;
    assign err       = r_err;

endmodule

// File: doc/sram_counter_host.md
Name: sram_counter_host

Overview:
- Host-side initiator for the SRAM multi-counter. It accepts high-level counter requests over a valid/ready interface and drives the counter's command port (valid/cmd/id/data).
- It captures the counter's fixed-latency READ responses into a credit-protected response FIFO with backpressure.
- A built-in dump engine reads all 256 counters back-to-back.
- It sits between the control/test agent and the counter, closing the loop on the counter's output_valid/output_id/output_data.

Parameters:
- RSP_DEPTH, 4: response FIFO entries; must be a power of 2 and >= 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_cmd  in  3  LOAD=0, CLEAR=1, INC=2, DEC=3, READ=4
- req_id  in  8  counter index
- req_data  in  8  load value (used by LOAD only)
- dump_start  in  1  single-cycle pulse; starts a 256-entry readback
- dump_busy  out  1  dump engine active
- ctr_valid  out  1  command valid to counter (registered)
- ctr_cmd  out  3  command to counter (registered)
- ctr_id  out  8  id to counter (registered)
- ctr_data  out  8  data to counter (registered)
- ctr_rsp_valid  in  1  counter output_valid
- ctr_rsp_id  in  8  counter output_id
- ctr_rsp_data  in  8  counter output_data
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  pop when rsp_valid & rsp_ready
- rsp_id  out  8  head entry id
- rsp_data  out  8  head entry data
- rsp_dump  out  1  head entry originated from the dump engine
- err  out  3  sticky: [0] unexpected response, [1] missing response, [2] id mismatch

Behaviour:
- Reset (async, rst_n=0):
  - ctr_valid/cmd/id/data = 0; FSM = IDLE; dump index = 0.
  - FIFO empty, so rsp_valid=0 and rsp_id/rsp_data/rsp_dump=0.
  - err=0, exp_q=0. req_ready=0 while in reset; it returns to 1 on the first cycle after release.
- Credit:
  - credit_avail = (fifo_count + ctr_rd + exp_q) < RSP_DEPTH.
  - ctr_rd = ctr_valid & (ctr_cmd==READ).
  - A same-cycle pop is not credited.
- req_ready = (state==IDLE) & credit_avail. This holds for all commands, so req_ready does not depend on req_cmd.
- Issue path:
  - An accepted request appears on ctr_* in the next cycle, for exactly 1 cycle.
  - ctr_data = req_data for LOAD, 0 otherwise.
  - Commands 5-7 are accepted and dropped: ctr_valid stays 0 and no error is flagged.
  - Without acceptance or a dump issue, ctr_valid=0.
- Response tracking:
  - Counter READ latency is exactly 1 cycle: response in cycle t+1 for ctr_* READ driven in cycle t.
  - Registers: exp_q <= ctr_rd; exp_id_q <= ctr_id; exp_dump_q <= dump-originated.
- Response cases at each cycle:
  - ctr_rsp_valid & exp_q: push {exp_id_q, ctr_rsp_data, exp_dump_q}. If ctr_rsp_id != exp_id_q, set err[2] and still push.
  - ctr_rsp_valid & !exp_q: set err[0]; discard.
  - exp_q & !ctr_rsp_valid: set err[1]; push nothing.
- FIFO:
  - Show-ahead; push and pop in the same cycle leaves the count unchanged.
  - Pop on empty is ignored.
  - Push when full cannot occur by credit; if it does, the data is dropped and err[0] is set.
- FSM:
  - IDLE -> DUMP on dump_start; index <= 0.
  - DUMP: req_ready=0 and dump_busy=1. Each cycle with credit_avail, issue READ id=index and increment index. After issuing id 255, return to IDLE with index = 0.
  - dump_start in DUMP is ignored.
  - A req accepted in the same cycle as dump_start: the request is issued first; DUMP begins the next cycle.
  - With rsp_ready held 1 and RSP_DEPTH>=4, the dump issues one READ per cycle: 256 consecutive cycles.
- Reset mid-operation:
  - The dump is abandoned and in-flight reads are forgotten.
  - A response arriving in the first cycle after release sets err[0].
- err bits clear only on reset.

Test Plan:
- Reset, then LOAD id=5 data=0x2A -> next cycle ctr_valid=1, ctr_cmd=0, ctr_id=5, ctr_data=0x2A; no rsp_valid; err=0.
- READ id=5, model answers 0x2A at t+1 -> rsp_valid=1, rsp_id=5, rsp_data=0x2A, rsp_dump=0; pop empties the FIFO.
- rsp_ready=0, 6 READs offered (RSP_DEPTH=4) -> exactly 4 accepted, then req_ready=0. One pop -> req_ready=1 and the 5th READ is accepted. Responses pop in issue order.
- dump_start with rsp_ready=1 -> dump_busy high for 256 cycles; ctr_id 0..255 consecutive; 256 responses with rsp_dump=1; req_ready=0 throughout; a second dump_start mid-dump is ignored.
- Errors:
  - Spurious ctr_rsp_valid -> err=3'b001.
  - Suppressed response after a READ -> err[1] set.
  - Response with ctr_rsp_id=7 for id 6 -> err[2] set and entry pushed with rsp_id=6.
- Assert rst_n=0 at dump index 100 -> ctr_valid, dump_busy and rsp_valid drop immediately. After release: IDLE, FIFO empty, req_ready=1, index restarts at 0 on the next dump.
